// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } memfsm_t;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Operand source: the Memory-stage result wins over the Writeback result.
   function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] src,
                                        input logic [REG_W-1:0] wreg_m,
                                        input logic             wen_m,
                                        input logic [REG_W-1:0] wreg_w,
                                        input logic             wen_w);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (src != REG_ZERO && src == wreg_m && wen_m)
         sel = FWD_MEM;
      else if (src != REG_ZERO && src == wreg_w && wen_w)
         sel = FWD_WB;
      return sel;
   endfunction

   // A non-zero destination that feeds either Decode source.
   function automatic logic dst_hits(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt);
      return (dst != REG_ZERO) && (dst == rs || dst == rt);
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (inc && count != {W{1'b1}})
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the five-stage pipeline: forwarding, stall/flush control,
// variable-latency memory wait tracking and hazard performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic [REG_W-1:0] RsE,
   input  logic [REG_W-1:0] RtE,
   input  logic [REG_W-1:0] WriteRegE,
   input  logic [REG_W-1:0] WriteRegM,
   input  logic [REG_W-1:0] WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             PCSrcD,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             StallW,
   output logic             FlushD,
   output logic             FlushE,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] LoadUseCount,
   output logic [CNT_W-1:0] BranchStallCount
);

   localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   if (MEM_TIMEOUT == 0) begin : g_bad_timeout
      $error("hazard_ctrl: MEM_TIMEOUT must be non-zero");
   end

   logic lwstall;
   logic branchstall;
   logic memstall;
   logic dstall;

   memfsm_t         state, state_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic            timeout_nxt;

   assign ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
   assign ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
   assign ForwardAD = (RsD != REG_ZERO) && (RsD == WriteRegM) && RegWriteM;
   assign ForwardBD = (RtD != REG_ZERO) && (RtD == WriteRegM) && RegWriteM;

   assign lwstall     = MemtoRegE && dst_hits(WriteRegE, RsD, RtD);
   assign branchstall = BranchD &&
                        ((RegWriteE && dst_hits(WriteRegE, RsD, RtD)) ||
                         (MemtoRegM && dst_hits(WriteRegM, RsD, RtD)));
   assign memstall    = MemReqM && !MemReadyM;
   assign dstall      = lwstall || branchstall;

   // A pending memory access freezes every stage and masks all other hazards.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      StallW = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (memstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         StallW = 1'b1;
      end else begin
         StallF = dstall;
         StallD = dstall;
         FlushE = dstall;
         FlushD = PCSrcD && !dstall;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         timer      <= '0;
         MemTimeout <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         MemTimeout <= timeout_nxt;
      end
   end

   // Timer counts WAIT cycles; the timeout only flags, it never releases the stall.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      timeout_nxt = MemTimeout;
      case (state)
         RUN: begin
            if (memstall) begin
               state_nxt = WAIT;
               timer_nxt = TW'(1);
            end
         end
         WAIT: begin
            if (timer == TW'(MEM_TIMEOUT))
               timeout_nxt = 1'b1;
            if (MemReadyM || !MemReqM) begin
               state_nxt = RUN;
               timer_nxt = '0;
            end else if (timer != TW'(MEM_TIMEOUT)) begin
               timer_nxt = timer + TW'(1);
            end
         end
         default: begin
            state_nxt = RUN;
            timer_nxt = '0;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (StallF),
      .count (StallCount)
   );

   sat_counter #(.W(CNT_W)) u_loaduse_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (lwstall && !memstall),
      .count (LoadUseCount)
   );

   // Overlapping load-use and branch hazards are attributed to load-use only.
   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (branchstall && !lwstall && !memstall),
      .count (BranchStallCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model.
module tb_hazard_ctrl;

   localparam int unsigned MT   = 4;
   localparam int unsigned CW   = 4;
   localparam int          MAXC = (1 << CW) - 1;

   logic       clk;
   logic       reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD, MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD;
   logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemTimeout;
   logic [CW-1:0] StallCount, LoadUseCount, BranchStallCount;

   int n_cmp;
   int n_err;

   hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
      .FlushD(FlushD), .FlushE(FlushE), .MemTimeout(MemTimeout),
      .StallCount(StallCount), .LoadUseCount(LoadUseCount),
      .BranchStallCount(BranchStallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_fwd(input logic [4:0] s);
      if (s == 5'd0) return 0;
      if (RegWriteM && s == WriteRegM) return 2;
      if (RegWriteW && s == WriteRegW) return 1;
      return 0;
   endfunction

   function automatic bit feeds_d(input logic [4:0] dst);
      return dst != 5'd0 && (dst == RsD || dst == RtD);
   endfunction

   function automatic int bump(input int c, input bit ev);
      int n;
      n = c + (ev ? 1 : 0);
      return (n > MAXC) ? MAXC : n;
   endfunction

   bit e_lw, e_br, e_mem, e_stallf;
   always_comb begin
      e_lw     = MemtoRegE && feeds_d(WriteRegE);
      e_br     = BranchD && ((RegWriteE && feeds_d(WriteRegE)) ||
                             (MemtoRegM && feeds_d(WriteRegM)));
      e_mem    = MemReqM && !MemReadyM;
      e_stallf = e_mem || e_lw || e_br;
   end

   // m_run: number of back-to-back memory-stall cycles just completed.
   int m_stall, m_lu, m_br, m_run;
   bit m_tmo;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_stall <= 0; m_lu <= 0; m_br <= 0; m_run <= 0; m_tmo <= 1'b0;
      end else begin
         m_stall <= bump(m_stall, e_stallf);
         m_lu    <= bump(m_lu, e_lw && !e_mem);
         m_br    <= bump(m_br, e_br && !e_lw && !e_mem);
         if (m_run >= int'(MT)) m_tmo <= 1'b1;
         m_run   <= e_mem ? m_run + 1 : 0;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      chk("m_ForwardAE", int'(ForwardAE), m_fwd(RsE));
      chk("m_ForwardBE", int'(ForwardBE), m_fwd(RtE));
      chk("m_ForwardAD", int'(ForwardAD), int'(RsD != 5'd0 && RsD == WriteRegM && RegWriteM));
      chk("m_ForwardBD", int'(ForwardBD), int'(RtD != 5'd0 && RtD == WriteRegM && RegWriteM));
      chk("m_StallF", int'(StallF), int'(e_stallf));
      chk("m_StallD", int'(StallD), int'(e_stallf));
      chk("m_StallE", int'(StallE), int'(e_mem));
      chk("m_StallM", int'(StallM), int'(e_mem));
      chk("m_StallW", int'(StallW), int'(e_mem));
      chk("m_FlushE", int'(FlushE), int'(!e_mem && (e_lw || e_br)));
      chk("m_FlushD", int'(FlushD), int'(!e_mem && PCSrcD && !(e_lw || e_br)));
      chk("m_MemTimeout", int'(MemTimeout), int'(m_tmo));
      chk("m_StallCount", int'(StallCount), m_stall);
      chk("m_LoadUseCount", int'(LoadUseCount), m_lu);
      chk("m_BranchStallCount", int'(BranchStallCount), m_br);
   end

   // ---------------- directed stimulus ----------------
   task automatic clr();
      RsD = '0; RtD = '0; RsE = '0; RtE = '0;
      WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PCSrcD = 0;
      MemReqM = 0; MemReadyM = 0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clr();
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      look();
      chk("rst_StallCount", int'(StallCount), 0);
      chk("rst_MemTimeout", int'(MemTimeout), 0);
      chk("rst_state", int'(dut.state), 0);
      next();
      reset = 1'b1;

      // forwarding priority
      RsE = 5; RtE = 5; RsD = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
      look();
      chk("fwd_AE_mem", int'(ForwardAE), 2);
      chk("fwd_BE_mem", int'(ForwardBE), 2);
      chk("fwd_AD", int'(ForwardAD), 1);
      next();
      RsE = 0;
      look();
      chk("fwd_AE_r0", int'(ForwardAE), 0);
      chk("fwd_BE_still", int'(ForwardBE), 2);
      next();
      RsE = 5; RegWriteM = 0;
      look();
      chk("fwd_AE_wb", int'(ForwardAE), 1);
      chk("fwd_AD_off", int'(ForwardAD), 0);
      next();

      // load-use
      clr(); MemtoRegE = 1; WriteRegE = 8; RsD = 8;
      look();
      chk("lu_StallF", int'(StallF), 1);
      chk("lu_StallD", int'(StallD), 1);
      chk("lu_FlushE", int'(FlushE), 1);
      chk("lu_StallE", int'(StallE), 0);
      chk("lu_cnt_before", int'(LoadUseCount), 0);
      next();
      WriteRegE = 0;
      look();
      chk("lu_cnt_after", int'(LoadUseCount), 1);
      chk("lu_r0_StallF", int'(StallF), 0);
      chk("lu_StallCount", int'(StallCount), 1);
      next();

      // branch hazard
      clr(); BranchD = 1; RtD = 3; RegWriteE = 1; WriteRegE = 3; PCSrcD = 1;
      look();
      chk("br_StallD", int'(StallD), 1);
      chk("br_FlushD", int'(FlushD), 0);
      next();
      RegWriteE = 0;
      look();
      chk("br_cnt", int'(BranchStallCount), 1);
      chk("br_FlushD_clear", int'(FlushD), 1);
      chk("br_StallD_clear", int'(StallD), 0);
      chk("br_StallCount", int'(StallCount), 2);
      next();

      // memory wait of three cycles with a concurrent load-use hazard
      clr(); MemReqM = 1; MemtoRegE = 1; WriteRegE = 8; RsD = 8;
      for (int k = 0; k < 3; k++) begin
         look();
         chk("mw_StallF", int'(StallF), 1);
         chk("mw_StallW", int'(StallW), 1);
         chk("mw_FlushE", int'(FlushE), 0);
         next();
      end
      MemReadyM = 1; MemtoRegE = 0;
      look();
      chk("mw_ready_StallW", int'(StallW), 0);
      chk("mw_ready_StallF", int'(StallF), 0);
      chk("mw_StallCount", int'(StallCount), 5);
      chk("mw_LoadUseCount", int'(LoadUseCount), 1);
      next();
      clr();
      look();
      chk("mw_state_run", int'(dut.state), 0);
      chk("mw_no_timeout", int'(MemTimeout), 0);
      next();

      // timeout after the fourth WAIT cycle
      MemReqM = 1;
      for (int k = 1; k <= 6; k++) begin
         look();
         chk("to_flag", int'(MemTimeout), (k == 6) ? 1 : 0);
         next();
      end
      MemReadyM = 1;
      look();
      chk("to_sticky_ready", int'(MemTimeout), 1);
      chk("to_StallCount", int'(StallCount), 11);
      next();
      clr();
      look();
      chk("to_sticky_run", int'(MemTimeout), 1);
      next();

      // counter saturation during a long wait
      MemReqM = 1;
      repeat (6) next();
      look();
      chk("sat_StallCount", int'(StallCount), MAXC);
      chk("sat_state_wait", int'(dut.state), 1);

      // asynchronous reset in the middle of WAIT
      #2 reset = 1'b0;
      #1;
      chk("arst_state", int'(dut.state), 0);
      chk("arst_MemTimeout", int'(MemTimeout), 0);
      chk("arst_StallCount", int'(StallCount), 0);
      chk("arst_comb_StallF", int'(StallF), 1);
      next();
      MemReqM = 0;
      reset = 1'b1;
      look();
      chk("post_StallF", int'(StallF), 0);
      chk("post_StallE", int'(StallE), 0);
      chk("post_StallCount", int'(StallCount), 0);
      next();
      repeat (2) next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
